// File: rtl/synthesijer_divn_seq.sv
// synthesijer_divn_seq: iterative radix-2 non-restoring divider, one quotient bit
// per clock, fixed WIDTH+2 cycle latency, Java truncating semantics.
// Optional one-entry request buffer: define SYNTHESIJER_DIV_QUEUE_EN.
module synthesijer_divn_seq #(
  parameter int WIDTH  = 64,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             nd,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] quantient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             valid
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   p_q;      // signed partial remainder, one guard bit
  logic [WIDTH-1:0] qt_q;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q;      // divisor magnitude
  logic             sgn_q_q;  // quotient negative
  logic             sgn_r_q;  // remainder negative (follows dividend)
  logic             zero_q;   // divisor was zero

`ifdef SYNTHESIJER_DIV_QUEUE_EN
  logic             pend_q;
  logic [WIDTH-1:0] pa_q;
  logic [WIDTH-1:0] pb_q;
`endif

  // Magnitude of an operand; |MIN| stays a valid W-bit unsigned value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if (SIGNED != 0 && x[WIDTH-1]) return -x;
    return x;
  endfunction

  logic             go_d;
  logic [WIDTH-1:0] sa_d, sb_d;
  logic [WIDTH:0]   p_sh_d, p_d;
  logic [WIDTH-1:0] rmag_d, q_out_d, r_out_d;

  // Pick the operands that start a division this cycle (pending slot first).
  always_comb begin
    go_d = 1'b0;
    sa_d = a;
    sb_d = b;
    if (state_q == IDLE) begin
`ifdef SYNTHESIJER_DIV_QUEUE_EN
      if (pend_q) begin
        go_d = 1'b1;
        sa_d = pa_q;
        sb_d = pb_q;
      end else begin
        go_d = nd;
      end
`else
      go_d = nd;
`endif
    end
  end

  // One non-restoring step plus the final correction terms.
  always_comb begin
    p_sh_d  = {p_q[WIDTH-1:0], qt_q[WIDTH-1]};
    p_d     = p_q[WIDTH] ? (p_sh_d + {1'b0, d_q}) : (p_sh_d - {1'b0, d_q});
    rmag_d  = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
    q_out_d = zero_q ? {WIDTH{1'b1}} : (sgn_q_q ? -qt_q : qt_q);
    r_out_d = sgn_r_q ? -rmag_d : rmag_d;
  end

`ifdef SYNTHESIJER_DIV_QUEUE_EN
  assign ready = (state_q == IDLE) | ~pend_q;
`else
  assign ready = (state_q == IDLE);
`endif
  assign busy = (state_q != IDLE);

  // Divider FSM, datapath and registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      qt_q        <= '0;
      d_q         <= '0;
      sgn_q_q     <= 1'b0;
      sgn_r_q     <= 1'b0;
      zero_q      <= 1'b0;
      quantient   <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      valid       <= 1'b0;
`ifdef SYNTHESIJER_DIV_QUEUE_EN
      pend_q      <= 1'b0;
      pa_q        <= '0;
      pb_q        <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_d) begin
            state_q <= CALC;
            cnt_q   <= CW'(WIDTH - 1);
            p_q     <= '0;
            qt_q    <= mag(sa_d);
            d_q     <= mag(sb_d);
            sgn_q_q <= (SIGNED != 0) & (sa_d[WIDTH-1] ^ sb_d[WIDTH-1]);
            sgn_r_q <= (SIGNED != 0) & sa_d[WIDTH-1];
            zero_q  <= (sb_d == '0);
          end
        end
        CALC: begin
          p_q   <= p_d;
          qt_q  <= {qt_q[WIDTH-2:0], ~p_d[WIDTH]};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          quantient   <= q_out_d;
          remainder   <= r_out_d;
          div_by_zero <= zero_q;
          valid       <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef SYNTHESIJER_DIV_QUEUE_EN
      // Slot drains when IDLE starts it; refills from nd whenever it is free.
      if (state_q == IDLE && pend_q) begin
        pend_q <= nd;
        if (nd) begin
          pa_q <= a;
          pb_q <= b;
        end
      end else if (state_q != IDLE && !pend_q && nd) begin
        pend_q <= 1'b1;
        pa_q   <= a;
        pb_q   <= b;
      end
`endif
    end
  end

endmodule
